config_loader: RTL

CONFIG_LOADER -- requirements
Module: config_loader

---
 rtl/config_loader.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/config_loader.sv
// Mapper configuration loader: a CPU writes staged settings at $5000-$5FFF after a
// power-on hold, commits them atomically to the active outputs, and may freeze them.
module config_loader (
    input  logic        m2,
    input  logic        reset_n,
    input  logic        romsel,
    input  logic        cpu_rw_in,
    input  logic [14:0] cpu_addr_in,
    input  logic [7:0]  cpu_data_in,
    output logic [12:0] cpu_base,
    output logic [6:0]  prg_mask,
    output logic [4:0]  chr_mask,
    output logic [1:0]  sram_page,
    output logic [4:0]  mapper,
    output logic        sram_enabled,
    output logic        prg_write_enabled,
    output logic        chr_write_enabled,
    output logic        map_rom_on_6000,
    output logic        four_screen,
    output logic        init_done,
    output logic        cfg_locked
);

    localparam int unsigned BASE_W  = 13;
    localparam int unsigned PMASK_W = 7;
    localparam int unsigned CMASK_W = 5;
    localparam int unsigned PAGE_W  = 2;
    localparam int unsigned MAP_W   = 5;
    localparam int unsigned CNT_W   = 4;

    localparam logic [CNT_W-1:0] INIT_CYCLES = CNT_W'(15);

    typedef struct packed {
        logic [BASE_W-1:0]  cpu_base;
        logic [PMASK_W-1:0] prg_mask;
        logic [CMASK_W-1:0] chr_mask;
        logic [PAGE_W-1:0]  sram_page;
        logic [MAP_W-1:0]   mapper;
        logic               sram_enabled;
        logic               prg_write_enabled;
        logic               chr_write_enabled;
        logic               map_rom_on_6000;
        logic               four_screen;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{
        cpu_base:          BASE_W'(0),
        prg_mask:          PMASK_W'(7'h7E),
        chr_mask:          CMASK_W'(5'h1F),
        sram_page:         PAGE_W'(0),
        mapper:            MAP_W'(0),
        sram_enabled:      1'b0,
        prg_write_enabled: 1'b0,
        chr_write_enabled: 1'b1,
        map_rom_on_6000:   1'b0,
        four_screen:       1'b0
    };

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_OPEN   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cfg_t             stage_q, stage_d;
    cfg_t             active_q, active_d;
    logic             init_done_d, cfg_locked_d;

    logic             cfg_wr_c;
    logic [2:0]       reg_sel_c;
    logic             unused_addr;

    // Address bits 11:3 only mirror the eight registers across the 4 KiB window.
    assign unused_addr = ^cpu_addr_in[11:3];

    assign cfg_wr_c  = !cpu_rw_in && romsel && (cpu_addr_in[14:12] == 3'b101);
    assign reg_sel_c = cpu_addr_in[2:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stage_d  = stage_q;
        active_d = active_q;
        unique case (state_q)
            ST_INIT: begin
                if (cnt_q != CNT_W'(0)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_OPEN;
                end
            end
            ST_OPEN: begin
                if (cfg_wr_c) begin
                    case (reg_sel_c)
                        3'd0: stage_d.cpu_base[12:5] = cpu_data_in;
                        3'd1: stage_d.cpu_base[4:0]  = cpu_data_in[7:3];
                        3'd2: stage_d.prg_mask       = cpu_data_in[6:0];
                        3'd3: begin
                            stage_d.chr_mask  = cpu_data_in[4:0];
                            stage_d.sram_page = cpu_data_in[6:5];
                        end
                        3'd4: stage_d.mapper = cpu_data_in[4:0];
                        3'd5: begin
                            stage_d.sram_enabled      = cpu_data_in[0];
                            stage_d.prg_write_enabled = cpu_data_in[1];
                            stage_d.chr_write_enabled = cpu_data_in[2];
                            stage_d.map_rom_on_6000   = cpu_data_in[3];
                            stage_d.four_screen       = cpu_data_in[4];
                        end
                        3'd7: begin
                            // Commit lands before the lock so a combined write freezes the new values.
                            if (cpu_data_in[0]) begin
                                active_d = stage_q;
                            end
                            if (cpu_data_in[7]) begin
                                state_d = ST_LOCKED;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_LOCKED: ;
            default: state_d = ST_INIT;
        endcase
        init_done_d  = (state_d != ST_INIT);
        cfg_locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(negedge m2 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_INIT;
            cnt_q      <= INIT_CYCLES;
            stage_q    <= CFG_RESET;
            active_q   <= CFG_RESET;
            init_done  <= 1'b0;
            cfg_locked <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stage_q    <= stage_d;
            active_q   <= active_d;
            init_done  <= init_done_d;
            cfg_locked <= cfg_locked_d;
        end
    end

    assign cpu_base          = active_q.cpu_base;
    assign prg_mask          = active_q.prg_mask;
    assign chr_mask          = active_q.chr_mask;
    assign sram_page         = active_q.sram_page;
    assign mapper            = active_q.mapper;
    assign sram_enabled      = active_q.sram_enabled;
    assign prg_write_enabled = active_q.prg_write_enabled;
    assign chr_write_enabled = active_q.chr_write_enabled;
    assign map_rom_on_6000   = active_q.map_rom_on_6000;
    assign four_screen       = active_q.four_screen;

endmodule
